// File: rtl/dm_store_load.sv
// dm_store_load: data memory for the single-cycle MIPS datapath.
// Stores (sw/sh/sb) merge byte lanes into the addressed word on the rising
// edge. Loads (lw/lh/lhu/lb/lbu) are combinational and return aligned,
// extended data. Misaligned, out-of-range or reserved stores are suppressed
// and latch ErrSticky until reset.
// Optional feature macro: DM_TRACE_EN (prints one line per performed store).
module dm_store_load #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  input  logic [1:0]  StoreOp,
  input  logic [2:0]  LoadOp,
  input  logic [31:0] PC,
  output logic [31:0] DMread,
  output logic        MisalignSt,
  output logic        ErrSticky
);

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } store_op_t;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LH  = 3'b001,
    LD_LHU = 3'b010,
    LD_LB  = 3'b011,
    LD_LBU = 3'b100
  } load_op_t;

  logic [31:0]      mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic [AW-1:0] idx;
  logic          in_range;
  logic          align_ok;
  logic [31:0]   word;
  logic [31:0]   merged;
  logic [15:0]   half;
  logic [7:0]    byte_sel;

  assign idx      = Addr[AW+1:2];
  assign in_range = (Addr[31:AW+2] == '0);

  // Current word contents; a word never written since reset reads as zero.
  assign word = (in_range && valid[idx]) ? mem[idx] : 32'h0;

  // Alignment rule for the requested store width; reserved op never passes.
  always_comb begin
    align_ok = 1'b0;
    unique case (store_op_t'(StoreOp))
      ST_SW:   align_ok = (Addr[1:0] == 2'b00);
      ST_SH:   align_ok = ~Addr[0];
      ST_SB:   align_ok = 1'b1;
      ST_RSV:  align_ok = 1'b0;
      default: align_ok = 1'b0;
    endcase
  end

  assign MisalignSt = MemWrite & (~align_ok | ~in_range);

  // Merge store data into the old word; untouched lanes keep their value.
  always_comb begin
    merged = word;
    unique case (store_op_t'(StoreOp))
      ST_SW: merged = WD;
      ST_SH: begin
        if (Addr[1]) merged[31:16] = WD[15:0];
        else         merged[15:0]  = WD[15:0];
      end
      ST_SB: begin
        unique case (Addr[1:0])
          2'd0:    merged[7:0]   = WD[7:0];
          2'd1:    merged[15:8]  = WD[7:0];
          2'd2:    merged[23:16] = WD[7:0];
          default: merged[31:24] = WD[7:0];
        endcase
      end
      default: merged = word;
    endcase
  end

  // NOTE: the storage array itself has no reset; a packed per-word valid
  // vector is cleared instead, so reset costs one vector clear rather than
  // a reset path on every memory bit, and zeroed words read back as 0.
  // Per-word valid bits and the sticky error flag; reset wins over a store.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all state updates on the same edge.
    if (reset) begin
      valid     <= '0;
      ErrSticky <= 1'b0;
    end else if (MemWrite) begin
      if (MisalignSt) ErrSticky  <= 1'b1;
      else            valid[idx] <= 1'b1;
    end
  end

  // Word write of the merged data for every performed store.
  always_ff @(posedge clk) begin
    if (!reset && MemWrite && !MisalignSt) mem[idx] <= merged;
  end

  // Load alignment and extension.
  always_comb begin
    half     = Addr[1] ? word[31:16] : word[15:0];
    byte_sel = word[7:0];
    unique case (Addr[1:0])
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    DMread = 32'h0;
    case (load_op_t'(LoadOp))
      LD_LW:   DMread = word;
      LD_LH:   DMread = {{16{half[15]}}, half};
      LD_LHU:  DMread = {16'h0, half};
      LD_LB:   DMread = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  DMread = {24'h0, byte_sel};
      default: DMread = 32'h0;
    endcase
  end

`ifdef DM_TRACE_EN
  // Trace line for each performed store, using the values the edge commits.
  always @(posedge clk) begin
    if (!reset && MemWrite && !MisalignSt)
      $display("@%08h: *%08h <= %08h", PC, {Addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_dm_store_load.sv
// Directed self-checking bench for dm_store_load.
module tb_dm_store_load;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic        MemWrite;
  logic [1:0]  StoreOp;
  logic [2:0]  LoadOp;
  logic [31:0] PC;
  logic [31:0] DMread;
  logic        MisalignSt;
  logic        ErrSticky;

  int checks = 0;
  int errors = 0;

  dm_store_load dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WD(WD), .MemWrite(MemWrite),
    .StoreOp(StoreOp), .LoadOp(LoadOp), .PC(PC), .DMread(DMread),
    .MisalignSt(MisalignSt), .ErrSticky(ErrSticky)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] SW = 2'b00, SH = 2'b01, SB = 2'b10, SRSV = 2'b11;
  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] op, output logic [31:0] d);
    @(negedge clk);
    Addr = a; LoadOp = op;
    #1;
    d = DMread;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] op,
                       output logic mis);
    @(negedge clk);
    Addr = a; WD = wd; StoreOp = op; MemWrite = 1'b1;
    #1;
    mis = MisalignSt;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  // Runs a list of loads against expected values.
  task automatic run_loads(input string tag, input logic [31:0] addrs [],
                           input logic [2:0] ops [], input logic [31:0] exps []);
    logic [31:0] d;
    for (int i = 0; i < addrs.size(); i++) begin
      load(addrs[i], ops[i], d);
      checks++;
      if (d !== exps[i]) begin
        errors++;
        $display("FAIL %s[%0d] addr=%h op=%0d got %h exp %h", tag, i, addrs[i], ops[i], d, exps[i]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    run_loads("reset_load", '{32'h0, 32'hFFC}, '{LW, LW}, '{32'h0, 32'h0});
    checks++;
    if (ErrSticky !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b exp 0", ErrSticky);
    end
  endtask

  task automatic test_sw();
    logic mis;
    store(32'h10, 32'h12345678, SW, mis);
    checks++;
    if (mis !== 1'b0) begin errors++; $display("FAIL sw_mis got %b exp 0", mis); end
    run_loads("sw", '{32'h10, 32'h13, 32'h10, 32'h12, 32'h12, 32'h1010, 32'h10},
              '{LW, LB, LBU, LH, LHU, LW, 3'd5},
              '{32'h12345678, 32'h12, 32'h78, 32'h1234, 32'h1234, 32'h0, 32'h0});
  endtask

  task automatic test_sb();
    logic mis;
    store(32'h11, 32'h000000AB, SB, mis);
    run_loads("sb", '{32'h10, 32'h11, 32'h11}, '{LW, LB, LBU},
              '{32'h1234AB78, 32'hFFFFFFAB, 32'h000000AB});
  endtask

  task automatic test_sh();
    logic mis;
    store(32'h22, 32'hFFFF8001, SH, mis);
    run_loads("sh", '{32'h20, 32'h22, 32'h22, 32'h20}, '{LW, LH, LHU, LH},
              '{32'h80010000, 32'hFFFF8001, 32'h00008001, 32'h0});
  endtask

  task automatic test_misaligned();
    logic mis;
    logic [31:0] addrs [4] = '{32'h13, 32'h21, 32'h1000, 32'h4};
    logic [1:0]  ops   [4] = '{SW, SH, SW, SRSV};
    for (int i = 0; i < 4; i++) begin
      store(addrs[i], 32'hCAFEF00D, ops[i], mis);
      checks++;
      if (mis !== 1'b1) begin
        errors++; $display("FAIL misalign_flag[%0d] got %b exp 1", i, mis);
      end
      checks++;
      if (ErrSticky !== 1'b1) begin
        errors++; $display("FAIL err_sticky[%0d] got %b exp 1", i, ErrSticky);
      end
    end
    run_loads("mis_unchanged", '{32'h10, 32'h20, 32'h0, 32'h4}, '{LW, LW, LW, LW},
              '{32'h1234AB78, 32'h80010000, 32'h0, 32'h0});
    // StoreOp ignored when MemWrite is low.
    @(negedge clk);
    StoreOp = SRSV; Addr = 32'h13; MemWrite = 1'b0;
    #1;
    checks++;
    if (MisalignSt !== 1'b0) begin
      errors++; $display("FAIL mis_idle got %b exp 0", MisalignSt);
    end
    do_reset();
    checks++;
    if (ErrSticky !== 1'b0) begin
      errors++; $display("FAIL err_clear got %b exp 0", ErrSticky);
    end
    run_loads("reset_clears", '{32'h10, 32'h20}, '{LW, LW}, '{32'h0, 32'h0});
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    Addr = 32'h4; WD = 32'hDEADBEEF; StoreOp = SW; MemWrite = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0; reset = 1'b0;
    run_loads("reset_prio", '{32'h4}, '{LW}, '{32'h0});
  endtask

  task automatic test_same_cycle();
    logic mis;
    store(32'h30, 32'h11111111, SW, mis);
    @(negedge clk);
    Addr = 32'h30; LoadOp = LW; WD = 32'h22222222; StoreOp = SW; MemWrite = 1'b1;
    #1;
    checks++;
    if (DMread !== 32'h11111111) begin
      errors++; $display("FAIL no_bypass got %h exp 11111111", DMread);
    end
    @(posedge clk); #1;
    MemWrite = 1'b0;
    checks++;
    if (DMread !== 32'h22222222) begin
      errors++; $display("FAIL after_edge got %h exp 22222222", DMread);
    end
  endtask

  task automatic test_trace();
    logic mis;
    PC = 32'h3000;
    store(32'h8, 32'h1, SW, mis);
    PC = 32'h0;
    run_loads("trace_store", '{32'h8, 32'hB}, '{LW, LBU}, '{32'h1, 32'h0});
  endtask

  initial begin
    reset = 1'b0; Addr = '0; WD = '0; MemWrite = 1'b0;
    StoreOp = SW; LoadOp = LW; PC = '0;
    test_reset();
    test_sw();
    test_sb();
    test_sh();
    test_misaligned();
    test_reset_priority();
    test_same_cycle();
    test_trace();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_store_load.md
Name: dm_store_load

Overview:
- Data memory for the single-cycle MIPS datapath; the write/storage end of the DMread path that feeds the writeback select.
- Performs sw/sh/sb stores with byte-lane merging on the clock edge.
- Combinationally returns lw/lh/lhu/lb/lbu data, aligned and extended, as DMread.
- Sits after the ALU, which supplies Addr, and before the writeback select.

Parameters:
- DEPTH, 1024, number of 32-bit words; word index = Addr[11:2] at default.
- AW, 10, word-index width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Addr  input  32  byte address from ALUout.
- WD  input  32  store data (rt value).
- MemWrite  input  1  store enable.
- StoreOp  input  2  00 sw, 01 sh, 10 sb, 11 reserved (no write).
- LoadOp  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, others return 32'b0.
- PC  input  32  PC of the current instruction; used only by the trace feature.
- DMread  output  32  load result, aligned and extended.
- MisalignSt  output  1  combinational: the current store is misaligned or out of range.
- ErrSticky  output  1  registered: set by any suppressed store.

Behaviour:
- Storage: mem[0..DEPTH-1], 32 bits each.
- Reset: on a rising clk edge with reset=1, every word becomes 0 and ErrSticky becomes 0.
  - Reset has priority over MemWrite in the same cycle.
  - DMread then reflects the zeroed memory combinationally.
- Index: idx = Addr[AW+1:2]. In range iff Addr < 4*DEPTH (Addr[31:AW+2]==0).
- Store, evaluated at posedge when reset=0 and MemWrite=1:
  - sw: requires Addr[1:0]==0; writes the whole word.
  - sh: requires Addr[0]==0. Addr[1]=0 writes bits 15:0 from WD[15:0]; Addr[1]=1 writes bits 31:16 from WD[15:0].
  - sb: byte lane Addr[1:0] (0 = bits 7:0 … 3 = bits 31:24) gets WD[7:0].
  - Unwritten lanes keep their old value (read-modify-write of the same word within the edge).
  - MisalignSt=1 when MemWrite=1 and the alignment rule fails, the address is out of range, or StoreOp=11.
  - When MisalignSt=1, no lane is written and ErrSticky is set to 1 at that edge.
- Load, combinational with no clock latency:
  - w = mem[idx]; w is 0 when out of range.
  - lw: w. Misaligned lw returns the word at idx; no flag is raised.
  - lh/lhu: half = Addr[1] ? w[31:16] : w[15:0]; sign- or zero-extended.
  - lb/lbu: byte selected by Addr[1:0]; sign- or zero-extended.
- Same-cycle read and write to the same word: DMread shows the old contents until the edge, then the new contents. There is no bypass.
- MemWrite=0: memory and ErrSticky unchanged; StoreOp ignored.
- ErrSticky clears only on reset.

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined: each performed (non-suppressed) store prints one simulation line after the edge, in the format "@<PC hex 8>: *<word address hex 8> <= <full merged word hex 8>". The word address is {Addr[31:2],2'b00}. Suppressed stores print nothing. The block behaves identically otherwise.
- Undefined: no $display is emitted, PC is unused, and the block is fully synthesizable.

Test Plan:
- Reset, then lw from Addr 0x0 and 0xFFC -> DMread=0x00000000 for both; ErrSticky=0.
- sw WD=0x12345678 @0x10, then lw @0x10 -> 0x12345678; lb @0x13 -> 0x00000012; lbu @0x10 -> 0x00000078; lh @0x12 -> 0x00001234.
- sb WD=0x000000AB @0x11 onto 0x12345678 -> word 0x1234AB78; lb @0x11 -> 0xFFFFFFAB; lbu -> 0x000000AB.
- sh WD=0xFFFF8001 @0x22 onto 0 -> word 0x80010000; lh @0x22 -> 0xFFFF8001; lhu -> 0x00008001.
- sw @0x13, sh @0x21, and sw @0x1000 (out of range) -> MisalignSt=1 in each cycle, memory unchanged, ErrSticky=1 after the first; reset -> ErrSticky=0.
- MemWrite=1 and reset=1 in the same cycle with sw 0xDEADBEEF @0x4 -> word at 0x4 reads 0 afterwards. With DM_TRACE_EN and PC=0x3000, sw 0x1 @0x8 -> "@00003000: *00000008 <= 00000001".
